// File: rtl/pwm_setpoint_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : pwm_setpoint_arbiter_if
// Description : Requester handshake and PWM output bundle for the setpoint arbiter.
// Revision    : 1.0  initial release
// ============================================================================
interface pwm_setpoint_arbiter_if #(
    parameter int NUM_REQ = 4
) ();
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_level;
    logic [NUM_REQ-1:0]   req_ready;
    logic [7:0]           pwm_voltage;
    logic                 pwm_power;
    logic                 at_target;
    logic                 busy;

    modport master (
        output req_valid, req_level,
        input  req_ready, pwm_voltage, pwm_power, at_target, busy
    );

    modport slave (
        input  req_valid, req_level,
        output req_ready, pwm_voltage, pwm_power, at_target, busy
    );
endinterface
`default_nettype wire

// File: rtl/pwm_setpoint_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : pwm_setpoint_arbiter
// Description : Round-robin setpoint arbiter with rate-limited ramp and delayed power-down.
// Revision    : 1.0  initial release
// ============================================================================
module pwm_setpoint_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int STEP      = 1,
    parameter int RAMP_DIV  = 256,
    parameter int OFF_DELAY = 1024
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    pwm_setpoint_arbiter_if.slave   bus
);
    localparam int c_PTR_W  = $clog2(NUM_REQ);
    localparam int c_TICK_W = (RAMP_DIV  > 1) ? $clog2(RAMP_DIV)  : 1;
    localparam int c_IDLE_W = (OFF_DELAY > 1) ? $clog2(OFF_DELAY) : 1;
    localparam logic [c_PTR_W-1:0]  c_PTR_LAST  = c_PTR_W'(NUM_REQ - 1);
    localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(RAMP_DIV - 1);
    localparam logic [c_IDLE_W-1:0] c_IDLE_LAST = c_IDLE_W'(OFF_DELAY - 1);
    localparam logic [8:0]          c_STEP      = 9'(STEP);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RAMP = 2'd1,
        S_HOLD = 2'd2
    } state_e;

    state_e               r_state,   w_state_nxt;
    logic [7:0]           r_target,  w_target_nxt;
    logic [7:0]           r_voltage, w_voltage_nxt;
    logic                 r_power,   w_power_nxt;
    logic                 r_at_target, w_at_target_nxt;
    logic [NUM_REQ-1:0]   r_ready,   w_ready_nxt;
    logic [c_PTR_W-1:0]   r_ptr,     w_ptr_nxt;
    logic [c_TICK_W-1:0]  r_tick,    w_tick_nxt;
    logic [c_IDLE_W-1:0]  r_idle,    w_idle_nxt;

    logic                 w_gnt_any;
    logic                 w_hi_any;
    logic [c_PTR_W-1:0]   w_hi_idx;
    logic [c_PTR_W-1:0]   w_lo_idx;
    logic [c_PTR_W-1:0]   w_gnt_idx;
    logic [7:0]           w_gnt_level;
    logic [NUM_REQ-1:0]   w_gnt_onehot;
    logic                 w_grant;
    logic [8:0]           w_up;
    logic [8:0]           w_dn;
    logic [7:0]           w_step;

    // Round-robin pick: lowest valid index at/above the pointer, else lowest overall.
    always_comb begin
        w_gnt_any = 1'b0;
        w_hi_any  = 1'b0;
        w_hi_idx  = '0;
        w_lo_idx  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (bus.req_valid[k]) begin
                w_gnt_any = 1'b1;
                w_lo_idx  = c_PTR_W'(k);
                if (c_PTR_W'(k) >= r_ptr) begin
                    w_hi_any = 1'b1;
                    w_hi_idx = c_PTR_W'(k);
                end
            end
        end
        w_gnt_idx = w_hi_any ? w_hi_idx : w_lo_idx;
    end

    always_comb begin
        w_gnt_level  = 8'd0;
        w_gnt_onehot = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_gnt_idx == c_PTR_W'(k)) begin
                w_gnt_level     = bus.req_level[8*k +: 8];
                w_gnt_onehot[k] = 1'b1;
            end
        end
    end

    // One step toward target in 9-bit arithmetic, clamped at the target.
    always_comb begin
        w_up = {1'b0, r_voltage} + c_STEP;
        w_dn = {1'b0, r_voltage} - c_STEP;
        if (r_target > r_voltage) begin
            w_step = (w_up >= {1'b0, r_target}) ? r_target : w_up[7:0];
        end else begin
            w_step = (w_dn[8] || (w_dn[7:0] <= r_target)) ? r_target : w_dn[7:0];
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_target_nxt  = r_target;
        w_voltage_nxt = r_voltage;
        w_power_nxt   = r_power;
        w_ready_nxt   = '0;
        w_ptr_nxt     = r_ptr;
        w_tick_nxt    = r_tick;
        w_idle_nxt    = r_idle;
        // No arbitration while ramping or in the blackout cycle that follows a grant.
        w_grant = (r_state != S_RAMP) && (r_ready == '0) && w_gnt_any;

        case (r_state)
            S_RAMP: begin
                if (r_tick == c_TICK_LAST) begin
                    w_tick_nxt    = '0;
                    w_voltage_nxt = w_step;
                    if (w_step == r_target) begin
                        w_state_nxt = S_HOLD;
                    end
                end else begin
                    w_tick_nxt = r_tick + 1'b1;
                end
            end
            S_HOLD: begin
                if (r_voltage == 8'd0) begin
                    if (r_idle == c_IDLE_LAST) begin
                        w_state_nxt = S_IDLE;
                        w_power_nxt = 1'b0;
                        w_idle_nxt  = '0;
                    end else begin
                        w_idle_nxt = r_idle + 1'b1;
                    end
                end else begin
                    w_idle_nxt = '0;
                end
            end
            default: begin
            end
        endcase

        // A grant overrides a power-down falling on the same edge.
        if (w_grant) begin
            w_target_nxt = w_gnt_level;
            w_ready_nxt  = w_gnt_onehot;
            w_ptr_nxt    = (w_gnt_idx == c_PTR_LAST) ? '0 : w_gnt_idx + 1'b1;
            w_idle_nxt   = '0;
            w_power_nxt  = 1'b1;
            if (w_gnt_level != r_voltage) begin
                w_state_nxt = S_RAMP;
                w_tick_nxt  = '0;
            end else begin
                w_state_nxt = S_HOLD;
            end
        end

        w_at_target_nxt = (w_state_nxt != S_RAMP) && (w_voltage_nxt == w_target_nxt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_target    <= 8'd0;
            r_voltage   <= 8'd0;
            r_power     <= 1'b0;
            r_at_target <= 1'b0;
            r_ready     <= '0;
            r_ptr       <= '0;
            r_tick      <= '0;
            r_idle      <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_target    <= w_target_nxt;
            r_voltage   <= w_voltage_nxt;
            r_power     <= w_power_nxt;
            r_at_target <= w_at_target_nxt;
            r_ready     <= w_ready_nxt;
            r_ptr       <= w_ptr_nxt;
            r_tick      <= w_tick_nxt;
            r_idle      <= w_idle_nxt;
        end
    end

    assign bus.req_ready   = r_ready;
    assign bus.pwm_voltage = r_voltage;
    assign bus.pwm_power   = r_power;
    assign bus.at_target   = r_at_target;
    assign bus.busy        = (r_state == S_RAMP);
endmodule
`default_nettype wire

// File: tb/tb_pwm_setpoint_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwm_setpoint_arbiter
// Description : Directed scoreboard bench for pwm_setpoint_arbiter (STEP=16, RAMP_DIV=4, OFF_DELAY=8).
// Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_pwm_setpoint_arbiter;
    localparam int NUM_REQ   = 4;
    localparam int STEP      = 16;
    localparam int RAMP_DIV  = 4;
    localparam int OFF_DELAY = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    pwm_setpoint_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

    pwm_setpoint_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .STEP     (STEP),
        .RAMP_DIV (RAMP_DIV),
        .OFF_DELAY(OFF_DELAY)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    logic [3:0] exp_grant[$];
    logic [7:0] exp_volt[$];
    int         exp_pdown[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Monitor: compares grants, voltage steps and power-downs against queued expectations.
    logic [7:0] prev_v  = 8'd0;
    logic       prev_p  = 1'b0;
    logic       prev_at = 1'b0;
    int         last_evt   = 0;
    int         last_quiet = 0;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            prev_v = 8'd0; prev_p = 1'b0; prev_at = 1'b0;
            last_evt = cyc; last_quiet = cyc;
        end else begin
            if (bus.req_ready != '0) begin
                if (exp_grant.size() == 0) fail_now("unexpected_grant");
                else check("grant_onehot", 32'(bus.req_ready), 32'(exp_grant.pop_front()));
                last_evt = cyc;
                last_quiet = cyc;
            end
            if (bus.pwm_voltage != prev_v) begin
                if (exp_volt.size() == 0) fail_now("unexpected_voltage_change");
                else check("voltage_step", 32'(bus.pwm_voltage), 32'(exp_volt.pop_front()));
                check("step_interval", 32'(cyc - last_evt), 32'(RAMP_DIV));
                last_evt = cyc;
                prev_v = bus.pwm_voltage;
            end
            if (bus.at_target && !prev_at) last_quiet = cyc;
            if (prev_p && !bus.pwm_power) begin
                if (exp_pdown.size() == 0) fail_now("unexpected_powerdown");
                else check("powerdown_delay", 32'(cyc - last_quiet), 32'(exp_pdown.pop_front()));
            end
            prev_p  = bus.pwm_power;
            prev_at = bus.at_target;
        end
    end

    task automatic step_clk();
        @(negedge clk);
        for (int i = 0; i < NUM_REQ; i++)
            if (bus.req_ready[i]) bus.req_valid[i] = 1'b0;
    endtask

    task automatic request(input int idx, input logic [7:0] level);
        bus.req_level[8*idx +: 8] = level;
        bus.req_valid[idx] = 1'b1;
    endtask

    task automatic wait_valid_clear(input int max, output int n);
        n = 0;
        while (bus.req_valid != '0 && n < max) begin step_clk(); n++; end
        if (bus.req_valid != '0) fail_now("timeout_waiting_for_grants");
    endtask

    task automatic wait_volt(input logic [7:0] v, input int max);
        int n = 0;
        while (bus.pwm_voltage != v && n < max) begin step_clk(); n++; end
        if (bus.pwm_voltage != v) fail_now("timeout_waiting_for_voltage");
    endtask

    task automatic wait_power(input logic p, input int max);
        int n = 0;
        while (bus.pwm_power != p && n < max) begin step_clk(); n++; end
        if (bus.pwm_power != p) fail_now("timeout_waiting_for_power");
    endtask

    initial begin
        int n;
        logic prev;
        bus.req_valid = '0;
        bus.req_level = '0;
        #1 rst_n = 1'b0;
        #1;
        check("rst_voltage", 32'(bus.pwm_voltage), 0);
        check("rst_power",   32'(bus.pwm_power), 0);
        check("rst_ready",   32'(bus.req_ready), 0);
        check("rst_busy",    32'(bus.busy), 0);
        check("rst_at_target", 32'(bus.at_target), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step_clk(); step_clk();
        check("idle_at_target", 32'(bus.at_target), 1);
        check("idle_power", 32'(bus.pwm_power), 0);

        // Ramp up from idle to 64
        exp_grant.push_back(4'b0001);
        exp_volt.push_back(8'd16); exp_volt.push_back(8'd32);
        exp_volt.push_back(8'd48); exp_volt.push_back(8'd64);
        request(0, 8'd64);
        step_clk();
        check("t1_power", 32'(bus.pwm_power), 1);
        check("t1_busy", 32'(bus.busy), 1);
        check("t1_at_target_low", 32'(bus.at_target), 0);
        wait_volt(8'd64, 40);
        check("t1_at_target", 32'(bus.at_target), 1);
        check("t1_busy_done", 32'(bus.busy), 0);

        // Ramp down with clamp at 40
        exp_grant.push_back(4'b0010);
        exp_volt.push_back(8'd48); exp_volt.push_back(8'd40);
        request(1, 8'd40);
        wait_volt(8'd40, 40);
        check("t2_at_target", 32'(bus.at_target), 1);

        // All four requesting the current level: one grant per two cycles from pointer 2
        exp_grant.push_back(4'b0100); exp_grant.push_back(4'b1000);
        exp_grant.push_back(4'b0001); exp_grant.push_back(4'b0010);
        for (int i = 0; i < NUM_REQ; i++) request(i, 8'd40);
        wait_valid_clear(40, n);
        check("t3_grant_cycles", 32'(n), 7);
        exp_grant.push_back(4'b0100); exp_grant.push_back(4'b0001);
        request(0, 8'd40); request(2, 8'd40);
        wait_valid_clear(20, n);

        // Ramp to zero then delayed power-down
        exp_grant.push_back(4'b0010);
        exp_volt.push_back(8'd24); exp_volt.push_back(8'd8); exp_volt.push_back(8'd0);
        exp_pdown.push_back(OFF_DELAY);
        request(1, 8'd0);
        wait_volt(8'd0, 40);
        check("t4_at_target", 32'(bus.at_target), 1);
        wait_power(1'b0, 20);
        step_clk();
        check("t4_idle_at_target", 32'(bus.at_target), 1);

        // Grant from idle at level 0, then a grant on the power-down edge wins
        exp_grant.push_back(4'b0100);
        request(2, 8'd0);
        step_clk();
        check("t4_idle_grant_power", 32'(bus.pwm_power), 1);
        repeat (7) step_clk();
        exp_grant.push_back(4'b1000);
        request(3, 8'd0);
        step_clk();
        check("t4_grant_wins_power", 32'(bus.pwm_power), 1);
        check("t4_grant_wins_ready", 32'(bus.req_ready), 32'(4'b1000));
        step_clk();
        check("t4_still_powered", 32'(bus.pwm_power), 1);
        exp_pdown.push_back(OFF_DELAY);
        wait_power(1'b0, 20);

        // Reset mid-ramp
        exp_grant.push_back(4'b0001);
        exp_volt.push_back(8'd16); exp_volt.push_back(8'd32);
        request(0, 8'd64);
        wait_volt(8'd32, 20);
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_voltage", 32'(bus.pwm_voltage), 0);
        check("t5_rst_power", 32'(bus.pwm_power), 0);
        check("t5_rst_busy", 32'(bus.busy), 0);
        check("t5_rst_ready", 32'(bus.req_ready), 0);
        bus.req_valid = '0;
        @(negedge clk);
        #1 rst_n = 1'b1;
        step_clk();
        check("t5_idle_power", 32'(bus.pwm_power), 0);
        check("t5_idle_busy", 32'(bus.busy), 0);
        check("t5_idle_voltage", 32'(bus.pwm_voltage), 0);
        exp_grant.push_back(4'b0001); exp_grant.push_back(4'b0010);
        exp_pdown.push_back(OFF_DELAY);
        request(0, 8'd0); request(1, 8'd0);
        wait_valid_clear(10, n);
        wait_power(1'b0, 30);

        // Request raised during a ramp waits for HOLD
        exp_grant.push_back(4'b0100);
        exp_volt.push_back(8'd16); exp_volt.push_back(8'd32);
        exp_grant.push_back(4'b1000);
        exp_volt.push_back(8'd48);
        request(2, 8'd32);
        wait_volt(8'd16, 20);
        request(3, 8'd48);
        n = 0;
        prev = bus.at_target;
        while (bus.req_ready == '0 && n < 30) begin
            prev = bus.at_target;
            step_clk();
            n++;
        end
        if (bus.req_ready == '0) fail_now("timeout_t6_grant");
        check("t6_hold_before_grant", 32'(prev), 1);
        check("t6_voltage_at_grant", 32'(bus.pwm_voltage), 32);
        wait_volt(8'd48, 20);
        check("t6_at_target", 32'(bus.at_target), 1);

        repeat (4) step_clk();
        check("left_grants", 32'(exp_grant.size()), 0);
        check("left_volts", 32'(exp_volt.size()), 0);
        check("left_pdowns", 32'(exp_pdown.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
